rs_nand: RTL and testbench
==========================

RS_NAND -- requirements
Module: rs_nand

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter FILTER_CYCLES, default 4, number of consecutive identical samples required by the glitch filter (legal 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Sn  input  1  set request, active-low, asynchronous to clk.
REQ-006 SHALL have port Rn  input  1  reset request, active-low, asynchronous to clk.
REQ-007 SHALL have port Q  output  1  latch true output, registered.
REQ-008 SHALL have port Qn  output  1  latch complement output, registered.
REQ-009 SHALL have port forbidden  output  1  high while the synchronized input pair is Sn=0, Rn=0.

Function
REQ-010 SHALL pass Sn and Rn each through a SYNC_STAGES-deep flop chain before any use.
REQ-011 SHALL decode the synchronized pair as follows: Sn=0,Rn=1 -> set (Q=1, Qn=0); Sn=1,Rn=0 -> clear (Q=0, Qn=1); Sn=1,Rn=1 -> hold; Sn=0,Rn=0 -> forbidden (Q=1, Qn=1), which is NAND-latch behaviour.
REQ-012 SHALL maintain an internal stored bit, updated only by set and clear; forbidden and hold SHALL leave it unchanged.
REQ-013 SHALL resolve an exit from forbidden directly to hold deterministically: Q and Qn return to the stored bit and its complement, with no race or oscillation.
REQ-014 SHALL resolve an exit from forbidden to set or clear by applying that set or clear normally.
REQ-015 SHALL register Q, Qn and forbidden, giving input-pin-to-output latency of exactly SYNC_STAGES+1 clk cycles (3 at defaults) with the filter compiled out.
REQ-016 SHALL guarantee that Qn equals the complement of Q in every state except forbidden.

Reset
REQ-017 SHALL asynchronously force Q=0, Qn=1, forbidden=0, stored bit=0, synchronizer flops=1 (the inactive level), and filter state=1,1 while rst_n=0.
REQ-018 SHALL resume sampling on the first rising clk edge after rst_n deasserts, with no spurious set or clear.

Configuration
REQ-019 SHALL support macro RS_NAND_GLITCH_FILTER_EN.
- Defined: the synchronized pair SHALL be accepted only after FILTER_CYCLES consecutive identical samples, adding FILTER_CYCLES-1 cycles of latency; a shorter pulse SHALL be ignored.
- Undefined: the filter is absent and the latency is per REQ-015.

Structure
REQ-020 SHALL place the input-state encoding (HOLD, CLEAR, SET, FORBID) as a 2-bit typedef in package rs_nand_pkg, together with the default parameter constants.
REQ-021 SHALL implement synchronization as sub-module rs_nand_sync, instantiated once per input.

Verification
REQ-022 Reset: rst_n=0 mid-cycle with Sn=0 -> Q=0, Qn=1 immediately (before any clk edge).
REQ-023 Set then hold: Sn=0,Rn=1 for 10 cycles, then Sn=1,Rn=1 -> Q=1, Qn=0 appears 3 cycles after the set, and Q stays 1 through the hold.
REQ-024 Clear: from Q=1, apply Sn=1,Rn=0 -> Q=0, Qn=1 after 3 cycles, and Q stays 0 after returning to 1,1.
REQ-025 Forbidden: Sn=0,Rn=0 -> Q=1, Qn=1, forbidden=1 after 3 cycles; then 1,1 -> Q and Qn revert to the pre-forbidden stored value (0/1 if the last action was a clear), and forbidden=0.
REQ-026 Full sequence (01,01,11,10,11,00,11,00,01,00,10,11, each held 50 cycles) -> final Q=0, Qn=1, and forbidden pulses exactly three times.
REQ-027 Filter build: a 2-cycle Sn=0 pulse with FILTER_CYCLES=4 -> Q unchanged; a 6-cycle pulse -> Q=1 after SYNC_STAGES+FILTER_CYCLES cycles.

Source files
------------

// File: rtl/rs_nand_pkg.sv
// Shared types and default constants for the rs_nand synchronized NAND-latch model.
// The encoding deliberately mirrors the raw {Sn, Rn} pin pair.
package rs_nand_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_FILTER_CYCLES = 4;

    typedef enum logic [1:0] {
        FORBID = 2'b00,
        SET    = 2'b01,
        CLEAR  = 2'b10,
        HOLD   = 2'b11
    } in_state_t;

    function automatic in_state_t decode(input logic [1:0] pair);
        return in_state_t'(pair);
    endfunction

endpackage

// File: rtl/rs_nand_sync.sv
// Multi-flop synchronizer for one active-low request line.
// Resets to 1 so an idle input never looks like a request.
module rs_nand_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rs_nand.sv
// Clocked emulation of a NAND RS latch with synchronized inputs and registered outputs.
// Optional glitch filter enabled by defining RS_NAND_GLITCH_FILTER_EN.
module rs_nand
    import rs_nand_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic Sn,
    input  logic Rn,
    output logic Q,
    output logic Qn,
    output logic forbidden
);

    logic       sn_sync;
    logic       rn_sync;
    logic [1:0] sync_pair;
    logic [1:0] pair_acc;

    rs_nand_sync #(.STAGES(SYNC_STAGES)) u_sync_sn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Sn),
        .q     (sn_sync)
    );

    rs_nand_sync #(.STAGES(SYNC_STAGES)) u_sync_rn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Rn),
        .q     (rn_sync)
    );

    assign sync_pair = {sn_sync, rn_sync};

`ifdef RS_NAND_GLITCH_FILTER_EN
    localparam int CW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FILTER_CYCLES - 1);

    logic [1:0]    cand;
    logic [1:0]    filt;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples equal cand have already been seen;
    // the FILTER_CYCLES-th matching sample is accepted in the same cycle it arrives.
    assign pair_acc = (sync_pair == cand && cnt == CNT_FULL) ? sync_pair : filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= 2'b11;
            filt <= 2'b11;
            cnt  <= '0;
        end else begin
            filt <= pair_acc;
            if (sync_pair != cand) begin
                cand <= sync_pair;
                cnt  <= CW'(1);
            end else if (cnt != CNT_FULL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign pair_acc = sync_pair;
`endif

    logic stored;
    logic stored_nxt;
    logic q_nxt;
    logic qn_nxt;
    logic forbidden_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stored_nxt    = stored;
        q_nxt         = stored;
        qn_nxt        = ~stored;
        forbidden_nxt = 1'b0;
        unique case (decode(pair_acc))
            SET: begin
                stored_nxt = 1'b1;
                q_nxt      = 1'b1;
                qn_nxt     = 1'b0;
            end
            CLEAR: begin
                stored_nxt = 1'b0;
                q_nxt      = 1'b0;
                qn_nxt     = 1'b1;
            end
            FORBID: begin
                // Stored bit untouched, so leaving FORBID to HOLD falls back to it cleanly.
                q_nxt         = 1'b1;
                qn_nxt        = 1'b1;
                forbidden_nxt = 1'b1;
            end
            HOLD: begin
                q_nxt  = stored;
                qn_nxt = ~stored;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored    <= 1'b0;
            Q         <= 1'b0;
            Qn        <= 1'b1;
            forbidden <= 1'b0;
        end else begin
            stored    <= stored_nxt;
            Q         <= q_nxt;
            Qn        <= qn_nxt;
            forbidden <= forbidden_nxt;
        end
    end

endmodule

// File: tb/tb_rs_nand.sv
// Self-checking bench for rs_nand: directed latch scenarios plus random pin traffic
// compared each cycle against a pin-history reference model.
module tb_rs_nand;

    localparam int SYNC = 2;
    localparam int FC   = 4;
    localparam int HL   = SYNC + FC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sn    = 1'b1;
    logic rn    = 1'b1;
    logic q, qn, forb;

    rs_nand #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Sn        (sn),
        .Rn        (rn),
        .Q         (q),
        .Qn        (qn),
        .forbidden (forb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // hist[0] is the pin pair sampled at the latest edge, hist[k] the one k edges earlier.
    logic [1:0] hist [HL];
    logic       m_stored;
    logic [1:0] m_acc;
    logic [2:0] m_out;
    int         forb_pulses;
    logic       prev_forb;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HL; i++) hist[i] = 2'b11;
        m_stored = 1'b0;
        m_acc    = 2'b11;
        m_out    = 3'b010;
    endtask

    // Output after an edge reflects the pair seen at the pins SYNC edges earlier;
    // with the filter, that pair must also have been steady for FC consecutive edges.
    task automatic model_edge();
        logic [1:0] eff;
        logic       steady;
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {sn, rn};
`ifdef RS_NAND_GLITCH_FILTER_EN
        steady = 1'b1;
        for (int i = SYNC + 1; i < SYNC + FC; i++)
            if (hist[i] != hist[SYNC]) steady = 1'b0;
        if (steady) m_acc = hist[SYNC];
        eff = m_acc;
`else
        steady = 1'b1;
        eff    = hist[SYNC];
`endif
        if (eff == 2'b01) m_stored = 1'b1;
        else if (eff == 2'b10) m_stored = 1'b0;
        if (eff == 2'b00) m_out = 3'b111;
        else              m_out = {m_stored, ~m_stored, 1'b0};
    endtask

    task automatic cycle(input logic [1:0] pair, input string tag);
        @(negedge clk);
        {sn, rn} = pair;
        @(posedge clk);
        model_edge();
        #1;
        check(tag, {q, qn, forb}, m_out);
        if (forb && !prev_forb) forb_pulses++;
        prev_forb = forb;
    endtask

    task automatic hold_pair(input logic [1:0] pair, input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(pair, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {q, qn, forb}, 3'b010);
        @(negedge clk);
        {sn, rn} = 2'b11;
        rst_n    = 1'b1;
        prev_forb = 1'b0;
    endtask

    logic [1:0] seq [12] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b00,
                             2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};

    initial begin
        model_reset();
        prev_forb   = 1'b0;
        forb_pulses = 0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", {q, qn, forb}, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // Set then hold, clear then hold.
        hold_pair(2'b01, 10, "set");
        hold_pair(2'b11, 10, "set_hold");
        check("after_set", {q, qn, forb}, 3'b100);
        hold_pair(2'b10, 10, "clear");
        hold_pair(2'b11, 10, "clear_hold");
        check("after_clear", {q, qn, forb}, 3'b010);

        // Forbidden, then direct exit to hold reverts to the stored value.
        hold_pair(2'b00, 10, "forbid");
        check("in_forbid", {q, qn, forb}, 3'b111);
        hold_pair(2'b11, 10, "forbid_exit");
        check("forbid_exit_final", {q, qn, forb}, 3'b010);

        // Asynchronous reset mid-cycle with a set request active.
        hold_pair(2'b01, 10, "preset");
        @(posedge clk);
        #3;
        sn    = 1'b0;
        rst_n = 1'b0;
        #1 check("async_reset", {q, qn, forb}, 3'b010);
        model_reset();
        @(posedge clk);
        #1 check("async_reset_hold", {q, qn, forb}, 3'b010);
        @(negedge clk);
        {sn, rn}  = 2'b11;
        rst_n     = 1'b1;
        prev_forb = 1'b0;
        hold_pair(2'b11, 8, "post_reset");

        // Full 12-step sequence, 50 cycles each.
        forb_pulses = 0;
        foreach (seq[i]) hold_pair(seq[i], 50, "sequence");
        check("seq_final", {q, qn, forb}, 3'b010);
        check("seq_forb_pulses", 3'(forb_pulses), 3'd3);

        // Short pulses (exercise the filter when compiled in).
        hold_pair(2'b01, 2, "short_pulse");
        hold_pair(2'b11, 12, "short_pulse_idle");
        hold_pair(2'b01, 6, "long_pulse");
        hold_pair(2'b11, 12, "long_pulse_idle");

        // Random traffic with random run lengths, including single-cycle glitches.
        do_reset();
        for (int k = 0; k < 120; k++) begin
            hold_pair(2'($urandom_range(0, 3)), $urandom_range(1, 8), "random");
        end
        hold_pair(2'b11, 12, "random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
